axis_pattern_gen: RTL

Parameterised AXI-Stream source generating packetised test patterns: increment, decrement, constant, and optionally LFSR.
- Runtime controls: step size and packet length; tlast is generated per packet.
- Packet counter output for test benches and on-chip traffic generation.
- Sits upstream of AXIS sinks, FIFOs and interconnect as a stimulus/loopback source.

---
 rtl/axis_pattern_gen_if.sv | 12 +
 rtl/axis_pattern_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen_if.sv
// AXI-Stream handshake bundle used by the pattern generator and its consumers.
interface axis_pattern_gen_if #(
    parameter int DW = 32
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// Packetised AXI-Stream test-pattern source (increment / decrement / constant).
// Define AXIS_PATTERN_GEN_LFSR_EN to make mode 2'b10 a Galois LFSR instead of increment.
module axis_pattern_gen #(
    parameter int                      BYTE_WIDTH = 4,
    parameter int                      LEN_W      = 16,
    parameter int                      CNT_W      = 32,
    parameter logic [8*BYTE_WIDTH-1:0] LFSR_TAPS  = 32'h80200003
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [8*BYTE_WIDTH-1:0] step,
    input  logic [LEN_W-1:0]        pkt_len,
    axis_pattern_gen_if.master      m_axis,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_count
);
    localparam int DW = 8 * BYTE_WIDTH;

    typedef enum logic {IDLE, ACTIVE} state_e;
    typedef enum logic [1:0] {MODE_INC, MODE_DEC, MODE_LFSR, MODE_CONST} mode_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [DW-1:0]      step_q, step_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [DW-1:0]      data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      data_adv;
    logic               is_last;
    logic               xfer;

    assign is_last = (state_q == ACTIVE) && (beat_q == len_q - LEN_W'(1));
    assign xfer    = (state_q == ACTIVE) && m_axis.tready;

    // Value presented on the beat after the current one completes.
    always_comb begin
        data_adv = data_q + step_q;
        case (mode_q)
            MODE_DEC:   data_adv = data_q - step_q;
            MODE_CONST: data_adv = data_q;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
            MODE_LFSR:  data_adv = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
`endif
            default:    data_adv = data_q + step_q;
        endcase
    end

`ifndef AXIS_PATTERN_GEN_LFSR_EN
    logic unused_taps;
    assign unused_taps = ^LFSR_TAPS;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        len_d   = len_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        data_d  = xfer ? data_adv : data_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    if (is_last) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        beat_d = '0;
                        if (!enable) begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Packet start: from IDLE, or back-to-back after a completed last beat.
        if (enable && ((state_q == IDLE) || (xfer && is_last))) begin
            mode_d = mode_e'(mode);
            step_d = step;
            len_d  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
            beat_d = '0;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
            if ((mode_e'(mode) == MODE_LFSR) && (data_d == '0)) begin
                data_d = DW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mode_q  <= MODE_INC;
            step_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis.tvalid = (state_q == ACTIVE);
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = is_last;
    assign busy          = (state_q == ACTIVE);
    assign pkt_count     = cnt_q;
endmodule
